pw_cmd_initiator: RTL and testbench

// Host-side initiator for the password-RAM command byte protocol that ctrl_logic answers.

---
 rtl/pw_cmd_initiator_if.sv | 49 ++++
 rtl/pw_cmd_initiator.sv | 182 ++++++++++++++++++
 tb/tb_pw_cmd_initiator.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pw_cmd_initiator_if.sv
// pw_cmd_initiator_if: request, outbound byte, inbound byte and completion channels
// between host logic, the password-RAM command initiator and the rx/tx fifo pair.
interface pw_cmd_initiator_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BLOCK_BYTES = 64
);
    logic                                  req_valid;
    logic                                  req_ready;
    logic [7:0]                            req_cmd;
    logic [7:0]                            req_idx;
    logic [2*BLOCK_BYTES*DATA_WIDTH-1:0]   req_data;

    logic [DATA_WIDTH-1:0]                 tx_data;
    logic                                  tx_valid;
    logic                                  tx_ready;

    logic [DATA_WIDTH-1:0]                 rx_data;
    logic                                  rx_valid;
    logic                                  rx_ready;

    logic                                  rsp_valid;
    logic                                  rsp_ready;
    logic [BLOCK_BYTES*DATA_WIDTH-1:0]     rsp_data;
    logic                                  rsp_err;

    // Initiator side
    modport master (
        input  req_valid, req_cmd, req_idx, req_data,
        output req_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready,
        output rsp_valid, rsp_data, rsp_err,
        input  rsp_ready
    );

    // Host / fifo side
    modport slave (
        output req_valid, req_cmd, req_idx, req_data,
        input  req_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready,
        input  rsp_valid, rsp_data, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/pw_cmd_initiator.sv
// pw_cmd_initiator: host-side initiator for the password-RAM command byte protocol.
// Sends cmd, idx and (for writes) the payload on tx; for reads gathers the 64-byte
// response into one 512-bit word. Define PW_RSP_TIMEOUT_EN to abort a stalled read
// response after TIMEOUT_CYCLES idle cycles.
module pw_cmd_initiator #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BLOCK_BYTES    = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    pw_cmd_initiator_if.master bus
);
    localparam int unsigned RspW    = BLOCK_BYTES * DATA_WIDTH;
    localparam int unsigned ReqW    = 2 * RspW;
    localparam logic [6:0]  LastOne = 7'(BLOCK_BYTES - 1);
    localparam logic [6:0]  LastTwo = 7'(2 * BLOCK_BYTES - 1);

    typedef enum logic [2:0] {StIdle, StCmd, StIdx, StData, StRsp, StDone} state_e;

    state_e          state_q;
    logic            is_read_q;
    logic [7:0]      idx_q;
    logic [ReqW-1:0] data_q;
    logic [6:0]      cnt_q;
    logic [6:0]      last_q;
    logic            req_ready_q;
    logic            tx_valid_q;
    logic [7:0]      tx_data_q;
    logic            rx_ready_q;
    logic            rsp_valid_q;
    logic [RspW-1:0] rsp_data_q;
    logic            rsp_err_q;

    logic [6:0]      cnt_inc;
    logic            cmd_legal;
    logic            tx_fire;
    logic            rx_fire;

`ifdef PW_RSP_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q;
`endif

    assign cnt_inc = cnt_q + 7'd1;
    assign tx_fire = tx_valid_q && bus.tx_ready;
    assign rx_fire = rx_ready_q && bus.rx_valid;

    assign bus.req_ready = req_ready_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.rx_ready  = rx_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    // Decode which command bytes the responder understands
    always_comb begin
        cmd_legal = 1'b0;
        case (bus.req_cmd)
            8'h01, 8'h02, 8'h03, 8'h81, 8'h82, 8'h83: cmd_legal = 1'b1;
            default:                                  cmd_legal = 1'b0;
        endcase
    end

    // Protocol FSM; every output is registered and set up one state ahead so the
    // next byte is already on tx_data in the cycle after an accept (no bubbles)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            is_read_q   <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
            req_ready_q <= 1'b1;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
`ifdef PW_RSP_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid && req_ready_q) begin
                        is_read_q   <= bus.req_cmd[7];
                        idx_q       <= bus.req_idx;
                        data_q      <= bus.req_data;
                        cnt_q       <= '0;
                        last_q      <= (bus.req_cmd == 8'h01) ? LastTwo : LastOne;
                        rsp_data_q  <= '0;
                        req_ready_q <= 1'b0;
                        if (cmd_legal) begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= bus.req_cmd;
                            rsp_err_q  <= 1'b0;
                            state_q    <= StCmd;
                        end else begin
                            // Illegal opcode: nothing goes on the wire, just report it
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StCmd: begin
                    if (tx_fire) begin
                        tx_data_q <= idx_q;
                        state_q   <= StIdx;
                    end
                end
                StIdx: begin
                    if (tx_fire) begin
                        if (is_read_q) begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= StRsp;
`ifdef PW_RSP_TIMEOUT_EN
                            tmo_q      <= '0;
`endif
                        end else begin
                            tx_data_q <= data_q[7:0];
                            state_q   <= StData;
                        end
                    end
                end
                StData: begin
                    if (tx_fire) begin
                        if (cnt_q == last_q) begin
                            tx_valid_q  <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            cnt_q     <= cnt_inc;
                            tx_data_q <= data_q[{cnt_inc, 3'b000} +: 8];
                        end
                    end
                end
                StRsp: begin
                    if (rx_fire) begin
                        rsp_data_q[{cnt_q[5:0], 3'b000} +: 8] <= bus.rx_data;
`ifdef PW_RSP_TIMEOUT_EN
                        tmo_q <= '0;
`endif
                        if (cnt_q == LastOne) begin
                            rx_ready_q  <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
`ifdef PW_RSP_TIMEOUT_EN
                    else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                        // Responder went quiet: hand back what arrived, flagged
                        rx_ready_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
`endif
                end
                StDone: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pw_cmd_initiator.sv
// tb_pw_cmd_initiator: directed bench for pw_cmd_initiator (writes, reads, back-pressure,
// illegal command, reset abort and, with PW_RSP_TIMEOUT_EN, response timeout).
module tb_pw_cmd_initiator;
`ifdef PW_RSP_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 4096;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] got [0:255];
    int r_ntx;
    int r_txcyc;
    bit r_stable;
    int r_nrx;
    bit r_done;
    int r_done_c;
    int r_last_acc_c;

    pw_cmd_initiator_if bus ();

    pw_cmd_initiator #(
        .DATA_WIDTH     (8),
        .BLOCK_BYTES    (64),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic send_req(input logic [7:0] cmd, input logic [7:0] idx,
                            input logic [1023:0] data);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_idx   = idx;
        bus.req_data  = data;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Drives tx_ready/rx stream, records tx bytes; leaves at negedge when rsp_valid seen
    task automatic run_txn(input int max_cycles, input bit toggle, input int rx_limit,
                           input bit stop_at_limit, input logic [7:0] rx_xor);
        logic [7:0] held;
        bit stalled;
        held = '0;
        stalled = 1'b0;
        r_ntx = 0;
        r_txcyc = 0;
        r_stable = 1'b1;
        r_nrx = 0;
        r_done = 1'b0;
        r_done_c = -1;
        r_last_acc_c = -1;
        for (int c = 0; c < max_cycles; c++) begin
            bus.tx_ready = toggle ? (c % 2 == 1) : 1'b1;
            bus.rx_valid = (r_nrx < rx_limit);
            bus.rx_data  = 8'(r_nrx) ^ rx_xor;
            @(negedge clk);
            if (bus.rsp_valid) begin
                r_done = 1'b1;
                r_done_c = c;
                break;
            end
            if (bus.tx_valid) begin
                r_txcyc++;
                if (stalled && bus.tx_data !== held) r_stable = 1'b0;
                if (bus.tx_ready) begin
                    got[r_ntx] = bus.tx_data;
                    r_ntx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = bus.tx_data;
                end
            end
            if (bus.rx_valid && bus.rx_ready) begin
                r_nrx++;
                r_last_acc_c = c;
            end
            @(posedge clk);
            #1;
            if (stop_at_limit && r_nrx == rx_limit) break;
        end
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    // Completes the rsp handshake and returns at the following negedge
    task automatic ack_rsp();
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_cmd = '0;
        bus.req_idx = '0;
        bus.req_data = '0;
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tx_valid: got %b, required 0", bus.tx_valid);
        end
        n_checks++;
        if (bus.rx_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_rx_ready: got %b, required 0", bus.rx_ready);
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready: got %b, required 1", bus.req_ready);
        end
        n_checks++;
        if (bus.rsp_data !== 512'd0 || bus.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp: got err %b data!=0 %b, required 0 0",
                               bus.rsp_err, bus.rsp_data != 512'd0);
        end
    endtask

    task automatic test_write_one();
        logic [1023:0] pl;
        int bad;
        for (int i = 0; i < 128; i++) pl[8*i +: 8] = (i < 64) ? 8'(i) : 8'hAA;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL w1_req_ready: got %b, required 1", bus.req_ready);
        end
        send_req(8'h02, 8'h00, pl);
        run_txn(300, 1'b0, 0, 1'b0, 8'h00);
        n_checks++;
        if (got[0] !== 8'h02 || r_ntx < 1) begin
            n_fail++; $display("FAIL w1_first_byte: got %h, required 02", got[0]);
        end
        n_checks++;
        if (r_ntx !== 66 || r_txcyc !== 66) begin
            n_fail++; $display("FAIL w1_count: got %0d bytes in %0d cycles, required 66 in 66",
                               r_ntx, r_txcyc);
        end
        bad = 0;
        for (int i = 0; i < 66; i++) begin
            if (got[i] !== ((i == 0) ? 8'h02 : (i == 1) ? 8'h00 : 8'(i - 2))) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL w1_stream: got %0d wrong bytes, required 0", bad);
        end
        n_checks++;
        if (r_done !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 512'd0) begin
            n_fail++; $display("FAIL w1_rsp: got done %b err %b, required done 1 err 0 data 0",
                               r_done, bus.rsp_err);
        end
        ack_rsp();
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL w1_ack: got rsp_valid %b req_ready %b, required 0 1",
                               bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_write_two();
        logic [1023:0] pl;
        int bad;
        int extra;
        for (int i = 0; i < 128; i++) pl[8*i +: 8] = 8'(i % 64);
        send_req(8'h01, 8'h00, pl);
        run_txn(400, 1'b0, 0, 1'b0, 8'h00);
        n_checks++;
        if (r_ntx !== 130) begin
            n_fail++; $display("FAIL w2_count: got %0d bytes, required 130", r_ntx);
        end
        bad = 0;
        for (int i = 0; i < 130; i++) begin
            if (got[i] !== ((i == 0) ? 8'h01 : (i == 1) ? 8'h00 : 8'((i - 2) % 64))) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL w2_stream: got %0d wrong bytes, required 0", bad);
        end
        n_checks++;
        if (r_done !== 1'b1 || bus.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL w2_rsp: got done %b err %b, required 1 0", r_done, bus.rsp_err);
        end
        ack_rsp();
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.rsp_valid !== 1'b0) extra++;
            @(negedge clk);
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++; $display("FAIL w2_single_rsp: got %0d extra rsp_valid cycles, required 0",
                               extra);
        end
    endtask

    task automatic test_read();
        logic [511:0] er;
        for (int k = 0; k < 64; k++) er[8*k +: 8] = 8'(k);
        send_req(8'h82, 8'h00, '0);
        run_txn(300, 1'b0, 64, 1'b0, 8'h00);
        n_checks++;
        if (r_ntx !== 2 || got[0] !== 8'h82 || got[1] !== 8'h00) begin
            n_fail++; $display("FAIL rd_tx: got %0d bytes %h %h, required 2 bytes 82 00",
                               r_ntx, got[0], got[1]);
        end
        n_checks++;
        if (r_done !== 1'b1 || r_nrx !== 64) begin
            n_fail++; $display("FAIL rd_done: got done %b rx %0d, required 1 64", r_done, r_nrx);
        end
        n_checks++;
        if (bus.rsp_data[7:0] !== 8'h00 || bus.rsp_data[511:504] !== 8'h3F) begin
            n_fail++; $display("FAIL rd_ends: got %h/%h, required 00/3f",
                               bus.rsp_data[7:0], bus.rsp_data[511:504]);
        end
        n_checks++;
        if (bus.rsp_data !== er || bus.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL rd_data: got err %b data %h, required err 0 data %h",
                               bus.rsp_err, bus.rsp_data, er);
        end
        n_checks++;
        if (bus.rx_ready !== 1'b0) begin
            n_fail++; $display("FAIL rd_rx_ready_done: got %b, required 0", bus.rx_ready);
        end
        ack_rsp();
    endtask

    task automatic test_illegal();
        send_req(8'h45, 8'h07, '0);
        run_txn(4, 1'b0, 0, 1'b0, 8'h00);
        n_checks++;
        if (r_done !== 1'b1 || r_done_c > 1) begin
            n_fail++; $display("FAIL ill_latency: got done %b at %0d, required done by 1",
                               r_done, r_done_c);
        end
        n_checks++;
        if (r_txcyc !== 0) begin
            n_fail++; $display("FAIL ill_no_tx: got %0d tx_valid cycles, required 0", r_txcyc);
        end
        n_checks++;
        if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 512'd0) begin
            n_fail++; $display("FAIL ill_rsp: got err %b data!=0 %b, required 1 0",
                               bus.rsp_err, bus.rsp_data != 512'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.req_ready !== 1'b0) begin
                n_fail++; $display("FAIL ill_hold%0d: got valid %b err %b req_ready %b, required 1 1 0",
                                   i, bus.rsp_valid, bus.rsp_err, bus.req_ready);
            end
        end
        ack_rsp();
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ill_ack: got req_ready %b, required 1", bus.req_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [1023:0] pl;
        int bad;
        for (int i = 0; i < 128; i++) pl[8*i +: 8] = (i < 64) ? 8'(i) : 8'h55;
        send_req(8'h02, 8'h00, pl);
        run_txn(400, 1'b1, 0, 1'b0, 8'h00);
        n_checks++;
        if (r_ntx !== 66) begin
            n_fail++; $display("FAIL bp_count: got %0d bytes, required 66", r_ntx);
        end
        bad = 0;
        for (int i = 0; i < 66; i++) begin
            if (got[i] !== ((i == 0) ? 8'h02 : (i == 1) ? 8'h00 : 8'(i - 2))) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_stream: got %0d wrong bytes, required 0", bad);
        end
        n_checks++;
        if (r_stable !== 1'b1) begin
            n_fail++; $display("FAIL bp_stable: got tx_data change while stalled, required stable");
        end
        n_checks++;
        if (r_done !== 1'b1 || bus.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL bp_rsp: got done %b err %b, required 1 0", r_done, bus.rsp_err);
        end
        ack_rsp();
    endtask

    task automatic test_reset_abort();
        logic [511:0] er;
        for (int k = 0; k < 64; k++) er[8*k +: 8] = 8'(k) ^ 8'hA5;
        send_req(8'h83, 8'h11, '0);
        run_txn(300, 1'b0, 10, 1'b1, 8'h00);
        n_checks++;
        if (r_nrx !== 10 || bus.rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL ab_progress: got rx %0d rx_ready %b, required 10 1",
                               r_nrx, bus.rx_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL ab_reset_now: got tx_valid %b rx_ready %b rsp_valid %b, required 0 0 0",
                               bus.tx_valid, bus.rx_ready, bus.rsp_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL ab_after: got req_ready %b rsp_valid %b, required 1 0",
                               bus.req_ready, bus.rsp_valid);
        end
        send_req(8'h81, 8'h05, '0);
        run_txn(300, 1'b0, 64, 1'b0, 8'hA5);
        n_checks++;
        if (r_ntx !== 2 || got[0] !== 8'h81 || got[1] !== 8'h05) begin
            n_fail++; $display("FAIL ab_rd_tx: got %0d bytes %h %h, required 2 bytes 81 05",
                               r_ntx, got[0], got[1]);
        end
        n_checks++;
        if (r_done !== 1'b1 || bus.rsp_data !== er || bus.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL ab_rd_rsp: got done %b err %b data %h, required 1 0 %h",
                               r_done, bus.rsp_err, bus.rsp_data, er);
        end
        ack_rsp();
    endtask

`ifdef PW_RSP_TIMEOUT_EN
    task automatic test_timeout();
        logic [511:0] er;
        er = '0;
        for (int k = 0; k < 5; k++) er[8*k +: 8] = 8'(k);
        send_req(8'h81, 8'h02, '0);
        run_txn(200, 1'b0, 5, 1'b0, 8'h00);
        n_checks++;
        if (r_done !== 1'b1 || bus.rsp_err !== 1'b1) begin
            n_fail++; $display("FAIL tmo_err: got done %b err %b, required 1 1", r_done, bus.rsp_err);
        end
        n_checks++;
        if (r_done_c - r_last_acc_c - 1 !== 16) begin
            n_fail++; $display("FAIL tmo_idle: got %0d idle cycles, required 16",
                               r_done_c - r_last_acc_c - 1);
        end
        n_checks++;
        if (bus.rsp_data !== er) begin
            n_fail++; $display("FAIL tmo_partial: got %h, required %h", bus.rsp_data, er);
        end
        bus.rx_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.rx_ready !== 1'b0) begin
            n_fail++; $display("FAIL tmo_rx_ready: got %b, required 0", bus.rx_ready);
        end
        bus.rx_valid = 1'b0;
        ack_rsp();
    endtask
`endif

    initial begin
        test_reset();
        test_write_one();
        test_write_two();
        test_read();
        test_illegal();
        test_backpressure();
        test_reset_abort();
`ifdef PW_RSP_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
